ptp_bridge_dma_ts_arb: RTL and testbench
========================================

Name: ptp_bridge_dma_ts_arb

Overview:
- Round-robin arbiter that merges the per-port egress timestamp streams produced by the msgDMA timestamp demux into one serial stream.
- Up to NUM_INTF requesters: 8 DMA channels plus 1 user port.
- Each requester presents a timestamp record: mandatory beat 0 plus optional beat 1 (qualified by its beat-1 valid).
- The record is popped from the requester and sent as a 1- or 2-beat AXI-S packet, tagged with the source port, toward the CSR/host timestamp readout path.

Parameters:
- TX_EGR_TS_WIDTH, 96, egress timestamp width.
- FINGERPRINT_FLD_WIDTH, 32, fingerprint field width.
- TDATA_WIDTH, TX_EGR_TS_WIDTH+FINGERPRINT_FLD_WIDTH, width of each beat.
- NUM_INTF, 9, number of requesters (8 DMA + 1 user).
- CNT_WIDTH, 32, width of the packet counter.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- port_en  in  NUM_INTF  per-requester enable; 0 = never granted.
- egrpt_0_tvalid  in  NUM_INTF  requester record valid.
- egrpt_0_tdata  in  NUM_INTF x TDATA_WIDTH  beat 0 data.
- egrpt_1_tvalid  in  NUM_INTF  beat 1 present (sampled with beat 0).
- egrpt_1_tdata  in  NUM_INTF x TDATA_WIDTH  beat 1 data.
- arb2egrpt_tready  out  NUM_INTF  one-hot pop pulse to requester.
- arb2snk_tvalid  out  1  output beat valid.
- arb2snk_tdata  out  TDATA_WIDTH  output beat data.
- arb2snk_tlast  out  1  last beat of packet.
- arb2snk_tuser  out  $clog2(NUM_INTF)  source port index; constant for the whole packet.
- snk2arb_tready  in  1  sink ready.
- arb_busy  out  1  high whenever state != IDLE.
- pkt_cnt  out  CNT_WIDTH  completed packets; saturates at all-ones.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - RR pointer last_gnt = NUM_INTF-1, so port 0 has first priority.
  - pkt_cnt = 0.
  - Reset mid-packet aborts the packet; no tvalid is asserted in the cycle after rst deasserts.
- Eligible set: egrpt_0_tvalid & port_en.
- State IDLE:
  - If the eligible set is non-empty, grant the first eligible index scanning last_gnt+1, last_gnt+2, … with wrap modulo NUM_INTF.
  - In the same cycle:
    - Pulse arb2egrpt_tready[g]=1 (exactly one bit, one cycle).
    - Latch beat 0 data, beat 1 data, egrpt_1_tvalid[g] (has1) and g.
    - Update last_gnt=g.
    - Go to SEND0.
  - Otherwise remain in IDLE with tready all 0.
- State SEND0:
  - arb2snk_tvalid=1, tdata=latched beat 0, tlast=!has1, tuser=g.
  - On snk2arb_tready: go to SEND1 if has1, else go to IDLE and increment pkt_cnt.
- State SEND1:
  - tvalid=1, tdata=latched beat 1, tlast=1.
  - On tready: go to IDLE and increment pkt_cnt.
- Output stability: arb2snk_* are registered and held stable while tvalid=1 and tready=0 (AXI-S rules). tvalid is never dropped without a handshake.
- Latency: request in IDLE → first output beat valid on the next cycle.
- Throughput: there is one IDLE cycle between packets. Sustained maximum is one 2-beat packet per 3 cycles.
- Requester rules:
  - Requesters hold tvalid/tdata until they see their tready pulse.
  - The arbiter never asserts tready while state != IDLE.
- port_en:
  - Sampled only in IDLE.
  - Deasserting port_en for the port currently being sent does not abort the packet.
- Fairness: with all NUM_INTF ports continuously valid, grants cycle 0,1,…,NUM_INTF-1,0. No port waits more than NUM_INTF-1 packets.
- Simultaneous events: a new request arriving in the same cycle a packet completes is considered in the next IDLE cycle, not the completion cycle.
- pkt_cnt holds at 2^CNT_WIDTH-1 and does not wrap.

Test Plan:
- Single request: reset, then port 3 valid with has1=0 and beat0=0xA5…A5. Required response:
  - Next cycle: tready[3] pulse.
  - Following cycle: tvalid=1, tuser=3, tlast=1, tdata=0xA5…A5.
  - pkt_cnt=1 after handshake.
- Two-beat packet with backpressure: port 8 valid, has1=1; sink tready low for 5 cycles. Required response:
  - Beat 0 held stable for 5 cycles, tlast=0.
  - Then beat 1 sent with tlast=1, tuser=8.
  - arb_busy high throughout.
- Round robin: ports 0, 2 and 8 continuously valid, sink always ready. Required response: grant order 0, 2, 8, 0, 2, 8, with a new packet start every 2 cycles (1-beat packets).
- Enable mask: port_en=9'h1FE, all ports valid. Required response: port 0 never granted; first grant is port 1.
- Reset mid-packet: assert rst while in SEND1. Required response:
  - Next cycle: tvalid=0, tready=0, pkt_cnt=0.
  - After release, the first grant goes to the lowest eligible port.
- Saturation: CNT_WIDTH=4, 20 packets sent. Required response: pkt_cnt stops at 15.

Source files
------------

// File: rtl/ptp_bridge_dma_ts_arb.sv
// Round-robin arbiter that merges per-port egress timestamp records
// (one or two beats each) into a single AXI-Stream, tagged with the source port.
module ptp_bridge_dma_ts_arb #(
  parameter int unsigned TX_EGR_TS_WIDTH       = 96,
  parameter int unsigned FINGERPRINT_FLD_WIDTH = 32,
  parameter int unsigned TDATA_WIDTH           = TX_EGR_TS_WIDTH + FINGERPRINT_FLD_WIDTH,
  parameter int unsigned NUM_INTF              = 9,
  parameter int unsigned CNT_WIDTH             = 32,
  localparam int unsigned IDX_W                = $clog2(NUM_INTF)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_INTF-1:0]                   port_en,
  input  logic [NUM_INTF-1:0]                   egrpt_0_tvalid,
  input  logic [NUM_INTF-1:0][TDATA_WIDTH-1:0]  egrpt_0_tdata,
  input  logic [NUM_INTF-1:0]                   egrpt_1_tvalid,
  input  logic [NUM_INTF-1:0][TDATA_WIDTH-1:0]  egrpt_1_tdata,
  output logic [NUM_INTF-1:0]                   arb2egrpt_tready,
  output logic                                  arb2snk_tvalid,
  output logic [TDATA_WIDTH-1:0]                arb2snk_tdata,
  output logic                                  arb2snk_tlast,
  output logic [IDX_W-1:0]                      arb2snk_tuser,
  input  logic                                  snk2arb_tready,
  output logic                                  arb_busy,
  output logic [CNT_WIDTH-1:0]                  pkt_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND0 = 2'd1,
    SEND1 = 2'd2
  } state_t;

  state_t                 state;
  logic [IDX_W-1:0]       last_gnt;
  logic                   has1;
  logic [TDATA_WIDTH-1:0] beat1;

  logic [NUM_INTF-1:0]    eligible;
  logic                   gnt_found;
  logic [IDX_W-1:0]       gnt_idx;
  int unsigned            scan_idx;

  assign eligible = egrpt_0_tvalid & port_en;

  // Pick the first eligible port after the last grant, wrapping around
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = 0;
    for (int unsigned i = 1; i <= NUM_INTF; i++) begin
      scan_idx = 32'(last_gnt) + i;
      if (scan_idx >= NUM_INTF) scan_idx = scan_idx - NUM_INTF;
      if (!gnt_found && eligible[IDX_W'(scan_idx)]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDX_W'(scan_idx);
      end
    end
  end

  // Pop pulse to the winner; only in IDLE and never while reset is applied
  always_comb begin
    arb2egrpt_tready = '0;
    if (!rst && (state == IDLE) && gnt_found) arb2egrpt_tready[gnt_idx] = 1'b1;
  end

  // Packet FSM with registered stream outputs, busy flag and saturating counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      last_gnt       <= IDX_W'(NUM_INTF - 1);
      has1           <= 1'b0;
      beat1          <= '0;
      arb2snk_tvalid <= 1'b0;
      arb2snk_tdata  <= '0;
      arb2snk_tlast  <= 1'b0;
      arb2snk_tuser  <= '0;
      arb_busy       <= 1'b0;
      pkt_cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_found) begin
            last_gnt       <= gnt_idx;
            has1           <= egrpt_1_tvalid[gnt_idx];
            beat1          <= egrpt_1_tdata[gnt_idx];
            arb2snk_tvalid <= 1'b1;
            arb2snk_tdata  <= egrpt_0_tdata[gnt_idx];
            arb2snk_tlast  <= !egrpt_1_tvalid[gnt_idx];
            arb2snk_tuser  <= gnt_idx;
            arb_busy       <= 1'b1;
            state          <= SEND0;
          end
        end
        SEND0: begin
          if (snk2arb_tready) begin
            if (has1) begin
              arb2snk_tdata <= beat1;
              arb2snk_tlast <= 1'b1;
              state         <= SEND1;
            end else begin
              arb2snk_tvalid <= 1'b0;
              arb2snk_tlast  <= 1'b0;
              arb_busy       <= 1'b0;
              state          <= IDLE;
              if (pkt_cnt != '1) pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
            end
          end
        end
        SEND1: begin
          if (snk2arb_tready) begin
            arb2snk_tvalid <= 1'b0;
            arb2snk_tlast  <= 1'b0;
            arb_busy       <= 1'b0;
            state          <= IDLE;
            if (pkt_cnt != '1) pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
          end
        end
        default: begin
          arb2snk_tvalid <= 1'b0;
          arb_busy       <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ptp_bridge_dma_ts_arb.sv
// Bench for the egress timestamp round-robin arbiter: directed vector table,
// hand-written corner sequences and a randomized run against a packet-level model.
module tb_ptp_bridge_dma_ts_arb;

  localparam int unsigned N  = 9;
  localparam int unsigned DW = 128;

  logic                   clk;
  logic                   rst;
  logic [N-1:0]           port_en;
  logic [N-1:0]           v0, v1;
  logic [N-1:0][DW-1:0]   d0, d1;
  logic                   srdy;

  logic [N-1:0]           rdy, s_rdy;
  logic                   tv, tl, bz, s_tv, s_tl, s_bz;
  logic [DW-1:0]          td, s_td;
  logic [3:0]             tu, s_tu;
  logic [31:0]            cnt;
  logic [3:0]             s_cnt;

  int checks = 0;
  int errors = 0;

  ptp_bridge_dma_ts_arb dut (
    .clk(clk), .rst(rst), .port_en(port_en),
    .egrpt_0_tvalid(v0), .egrpt_0_tdata(d0),
    .egrpt_1_tvalid(v1), .egrpt_1_tdata(d1),
    .arb2egrpt_tready(rdy),
    .arb2snk_tvalid(tv), .arb2snk_tdata(td), .arb2snk_tlast(tl), .arb2snk_tuser(tu),
    .snk2arb_tready(srdy), .arb_busy(bz), .pkt_cnt(cnt)
  );

  // Same stimulus into a narrow-counter instance to observe saturation
  ptp_bridge_dma_ts_arb #(.CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst), .port_en(port_en),
    .egrpt_0_tvalid(v0), .egrpt_0_tdata(d0),
    .egrpt_1_tvalid(v1), .egrpt_1_tdata(d1),
    .arb2egrpt_tready(s_rdy),
    .arb2snk_tvalid(s_tv), .arb2snk_tdata(s_td), .arb2snk_tlast(s_tl), .arb2snk_tuser(s_tu),
    .snk2arb_tready(srdy), .arb_busy(s_bz), .pkt_cnt(s_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [DW-1:0] b0(int p);
    logic [7:0] x;
    x = 8'(8'hA2 + p);
    return {16{x}};
  endfunction

  function automatic logic [DW-1:0] b1(int p);
    logic [7:0] x;
    x = 8'(8'h50 + p);
    return {16{x}};
  endfunction

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare all observable outputs against one set of expectations
  task automatic cmp(string tag, logic [N-1:0] erdy, logic etv, logic etl,
                     logic [3:0] etu, logic [DW-1:0] etd, logic ebz, int ecnt);
    logic [3:0] esat;
    esat = (ecnt > 15) ? 4'd15 : 4'(ecnt);
    chk({tag, ".tready"}, DW'(rdy), DW'(erdy));
    chk({tag, ".tvalid"}, DW'(tv), DW'(etv));
    chk({tag, ".busy"}, DW'(bz), DW'(ebz));
    chk({tag, ".pkt_cnt"}, DW'(cnt), DW'(32'(ecnt)));
    chk({tag, ".sat_cnt"}, DW'(s_cnt), DW'(esat));
    if (etv) begin
      chk({tag, ".tlast"}, DW'(tl), DW'(etl));
      chk({tag, ".tuser"}, DW'(tu), DW'(etu));
      chk({tag, ".tdata"}, td, etd);
    end
  endtask

  // One directed cycle: inputs already applied, check mid-cycle, advance
  task automatic cyc(string tag, logic [N-1:0] erdy, logic etv, logic etl,
                     logic [3:0] etu, logic [DW-1:0] etd, logic ebz, int ecnt);
    @(negedge clk);
    cmp(tag, erdy, etv, etl, etu, etd, ebz, ecnt);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic         rst;
    logic [N-1:0] en, v0, v1;
    logic         srdy;
    logic [N-1:0] rdy;
    logic         tv, tl, eb;
    logic [3:0]   tu;
    logic         bz;
    int           cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic r, logic [N-1:0] en, logic [N-1:0] a0, logic [N-1:0] a1,
                              logic sr, logic [N-1:0] erdy, logic etv, logic etl, logic eb,
                              logic [3:0] etu, logic ebz, int ecnt);
    vec_t x;
    x.rst = r; x.en = en; x.v0 = a0; x.v1 = a1; x.srdy = sr;
    x.rdy = erdy; x.tv = etv; x.tl = etl; x.eb = eb; x.tu = etu; x.bz = ebz; x.cnt = ecnt;
    tbl.push_back(x);
  endfunction

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
    logic [3:0]    u;
  } beat_t;

  // Randomized-phase model state
  beat_t         q[$];
  int            mlast;
  int            mcnt;
  logic          rpres[N];
  logic          rhas[N];
  logic [DW-1:0] rq0[N];
  logic [DW-1:0] rq1[N];

  initial begin
    rst = 1'b1; port_en = '1; v0 = '0; v1 = '0; srdy = 1'b1;
    for (int p = 0; p < int'(N); p++) begin
      d0[p] = b0(p);
      d1[p] = b1(p);
    end
    @(posedge clk);
    #1;

    // Vector table: reset, single request, reset gating, round robin, enable mask
    //   rst en      v0      v1    srdy rdy     tv tl eb tu bz cnt
    add(1, 9'h1FF, 9'h000, 9'h0, 1, 9'h000, 0, 0, 0, 0, 0, 0);
    add(0, 9'h1FF, 9'h000, 9'h0, 1, 9'h000, 0, 0, 0, 0, 0, 0);
    add(0, 9'h1FF, 9'h008, 9'h0, 1, 9'h008, 0, 0, 0, 0, 0, 0);
    add(0, 9'h1FF, 9'h000, 9'h0, 1, 9'h000, 1, 1, 0, 3, 1, 0);
    add(0, 9'h1FF, 9'h000, 9'h0, 1, 9'h000, 0, 0, 0, 0, 0, 1);
    add(1, 9'h1FF, 9'h1FF, 9'h0, 1, 9'h000, 0, 0, 0, 0, 0, 1);
    add(0, 9'h1FF, 9'h000, 9'h0, 1, 9'h000, 0, 0, 0, 0, 0, 0);
    add(0, 9'h1FF, 9'h105, 9'h0, 1, 9'h001, 0, 0, 0, 0, 0, 0);
    add(0, 9'h1FF, 9'h105, 9'h0, 1, 9'h000, 1, 1, 0, 0, 1, 0);
    add(0, 9'h1FF, 9'h105, 9'h0, 1, 9'h004, 0, 0, 0, 0, 0, 1);
    add(0, 9'h1FF, 9'h105, 9'h0, 1, 9'h000, 1, 1, 0, 2, 1, 1);
    add(0, 9'h1FF, 9'h105, 9'h0, 1, 9'h100, 0, 0, 0, 0, 0, 2);
    add(0, 9'h1FF, 9'h105, 9'h0, 1, 9'h000, 1, 1, 0, 8, 1, 2);
    add(0, 9'h1FF, 9'h105, 9'h0, 1, 9'h001, 0, 0, 0, 0, 0, 3);
    add(0, 9'h1FF, 9'h105, 9'h0, 1, 9'h000, 1, 1, 0, 0, 1, 3);
    add(0, 9'h1FF, 9'h105, 9'h0, 1, 9'h004, 0, 0, 0, 0, 0, 4);
    add(0, 9'h1FF, 9'h105, 9'h0, 1, 9'h000, 1, 1, 0, 2, 1, 4);
    add(0, 9'h1FF, 9'h105, 9'h0, 1, 9'h100, 0, 0, 0, 0, 0, 5);
    add(0, 9'h1FF, 9'h105, 9'h0, 1, 9'h000, 1, 1, 0, 8, 1, 5);
    add(0, 9'h1FE, 9'h1FF, 9'h0, 1, 9'h002, 0, 0, 0, 0, 0, 6);
    add(0, 9'h1FE, 9'h1FF, 9'h0, 1, 9'h000, 1, 1, 0, 1, 1, 6);
    add(0, 9'h1FE, 9'h1FF, 9'h0, 1, 9'h004, 0, 0, 0, 0, 0, 7);
    add(0, 9'h1FE, 9'h1FF, 9'h0, 1, 9'h000, 1, 1, 0, 2, 1, 7);
    add(0, 9'h1FF, 9'h000, 9'h0, 1, 9'h000, 0, 0, 0, 0, 0, 8);

    foreach (tbl[i]) begin
      rst = tbl[i].rst; port_en = tbl[i].en; v0 = tbl[i].v0; v1 = tbl[i].v1; srdy = tbl[i].srdy;
      cyc($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].tv, tbl[i].tl, tbl[i].tu,
          tbl[i].eb ? b1(int'(tbl[i].tu)) : b0(int'(tbl[i].tu)), tbl[i].bz, tbl[i].cnt);
    end

    // Two-beat packet from port 8 with 5 cycles of sink backpressure
    port_en = '1; v0 = 9'h100; v1 = 9'h100; srdy = 1'b0;
    cyc("bp_grant", 9'h100, 0, 0, 0, '0, 0, 8);
    v0 = '0; v1 = '0;
    for (int k = 0; k < 5; k++) cyc($sformatf("bp_hold%0d", k), 9'h000, 1, 0, 8, b0(8), 1, 8);
    srdy = 1'b1;
    cyc("bp_beat0", 9'h000, 1, 0, 8, b0(8), 1, 8);
    cyc("bp_beat1", 9'h000, 1, 1, 8, b1(8), 1, 8);
    cyc("bp_done",  9'h000, 0, 0, 0, '0, 0, 9);

    // Reset while the second beat is on the bus
    v0 = 9'h020; v1 = 9'h020;
    cyc("rm_grant", 9'h020, 0, 0, 0, '0, 0, 9);
    v0 = '0; v1 = '0;
    cyc("rm_beat0", 9'h000, 1, 0, 5, b0(5), 1, 9);
    rst = 1'b1;
    cyc("rm_beat1", 9'h000, 1, 1, 5, b1(5), 1, 9);
    rst = 1'b0;
    cyc("rm_after", 9'h000, 0, 0, 0, '0, 0, 0);
    v0 = 9'h090;
    cyc("rm_g4",    9'h010, 0, 0, 0, '0, 0, 0);
    v0 = 9'h080;
    cyc("rm_p4",    9'h000, 1, 1, 4, b0(4), 1, 0);
    cyc("rm_g7",    9'h080, 0, 0, 0, '0, 0, 1);
    v0 = '0;
    cyc("rm_p7",    9'h000, 1, 1, 7, b0(7), 1, 1);
    cyc("rm_idle",  9'h000, 0, 0, 0, '0, 0, 2);

    // Randomized traffic against the packet-level model
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    mlast = int'(N) - 1;
    mcnt = 0;
    for (int p = 0; p < int'(N); p++) rpres[p] = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      int            gp;
      logic [N-1:0]  erdy;
      beat_t         f;
      beat_t         nb;

      for (int p = 0; p < int'(N); p++) begin
        if (!rpres[p] && $urandom_range(2) == 0) begin
          rpres[p] = 1'b1;
          rhas[p]  = 1'($urandom_range(1));
          rq0[p]   = rnd128();
          rq1[p]   = rnd128();
        end
        v0[p] = rpres[p];
        v1[p] = rpres[p] & rhas[p];
        d0[p] = rq0[p];
        d1[p] = rq1[p];
      end
      if ($urandom_range(19) == 0) port_en = N'($urandom | $urandom);
      rst  = ($urandom_range(399) == 0);
      srdy = ($urandom_range(3) != 0);

      gp = -1;
      if (!rst && q.size() == 0) begin
        for (int k = 1; k <= int'(N); k++) begin
          int p;
          p = (mlast + k) % int'(N);
          if (rpres[p] && port_en[p]) begin
            gp = p;
            break;
          end
        end
      end
      erdy = (gp >= 0) ? (N'(1) << gp) : '0;
      f = '{d: '0, l: 1'b0, u: 4'd0};
      if (q.size() != 0) f = q[0];

      @(negedge clk);
      cmp($sformatf("rnd%0d", c), erdy, q.size() != 0, f.l, f.u, f.d, q.size() != 0, mcnt);

      if (rst) begin
        q.delete();
        mlast = int'(N) - 1;
        mcnt = 0;
      end else if (q.size() != 0) begin
        if (srdy) begin
          void'(q.pop_front());
          if (q.size() == 0) mcnt++;
        end
      end else if (gp >= 0) begin
        nb.d = rq0[gp]; nb.l = !rhas[gp]; nb.u = 4'(gp);
        q.push_back(nb);
        if (rhas[gp]) begin
          nb.d = rq1[gp]; nb.l = 1'b1;
          q.push_back(nb);
        end
        mlast = gp;
        rpres[gp] = 1'b0;
      end

      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
